// File: rtl/k_nns_accum_seq.sv
// Sequential k-NN centroid accumulator: latches K (x,y) neighbours, sums one per cycle.
// Optional KNN_SKIP_EMPTY_EN: all-zero entries are not added or counted.
module k_nns_accum_seq #(
  parameter  int W    = 32,
  parameter  int K    = 10,
  localparam int LOGK = $clog2(K + 1),
  localparam int SW   = W + LOGK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2*W*K-1:0]  nn_in,
  output logic              busy,
  output logic              done,
  output logic [SW-1:0]     sum_x,
  output logic [SW-1:0]     sum_y,
  output logic [LOGK-1:0]   count
);

  localparam int IW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t                  state, state_nxt;
  logic [K-1:0][2*W-1:0]   lst;
  logic [IW-1:0]           idx;
  logic [SW-1:0]           sx, sy;
  logic [LOGK-1:0]         cnt;
  logic [2*W-1:0]          ent;
  logic                    take, last, launch;

  always_comb begin
    ent    = lst[idx];
    last   = (idx == IW'(K - 1));
    launch = start && (state != ACC);
`ifdef KNN_SKIP_EMPTY_EN
    take   = |ent;
`else
    take   = 1'b1;
`endif
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = ACC;
      ACC: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? ACC : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lst   <= '0;
      idx   <= '0;
      sx    <= '0;
      sy    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        lst <= nn_in;
        idx <= '0;
        sx  <= '0;
        sy  <= '0;
        cnt <= '0;
      end else if (state == ACC) begin
        // idx may step past K-1 on the last cycle; it is reloaded on the next launch
        idx <= idx + IW'(1);
        if (take) begin
          sx  <= sx + SW'(ent[2*W-1:W]);
          sy  <= sy + SW'(ent[W-1:0]);
          cnt <= cnt + LOGK'(1);
        end
      end
    end
  end

  assign sum_x = sx;
  assign sum_y = sy;
  assign count = cnt;

endmodule
